mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port, read-only lisp word memory (1-cycle registered read) between
//  NumReq requesters (evaluator, allocator, GC scanner). Round-robin arbitration,
//  valid/ready request and response handshakes, one outstanding access at a time.
//  Drives the memory address; routes registered read data back to the granted requester.
// PARAMETERS
//  NumReq   2     number of requesters (>=2)
//  MemSize  1024  words in attached memory; addresses >= MemSize are rejected with error
// PORTS
//  clk          in   1                 single clock, all logic on posedge
//  rst_n        in   1                 asynchronous, active-low reset
//  req_valid    in   NumReq            per-requester read request
//  req_addr     in   NumReq x (W)      per-requester word address, W = lisp::word_size+1
//  req_ready    out  NumReq            one-hot accept; request taken when valid&&ready
//  rsp_valid    out  NumReq            one-hot response valid to owner of access
//  rsp_ready    in   NumReq            per-requester response accept
//  rsp_data     out  W                 read data (shared bus, qualified by rsp_valid)
//  rsp_err      out  1                 address out of range (qualified by rsp_valid)
//  mem_addr     out  W                 to memory addr_in; registered
//  mem_rdata    in   W                 from memory data_out
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, owner=0, mem_addr=0, err_q=0;
//   req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0. Mid-access reset aborts silently.
//  States:
//   IDLE: if any req_valid, winner = first valid at/after rr_ptr (wrapping);
//    req_ready[winner]=1 combinationally this cycle (only one bit ever set).
//    On edge: owner<=winner, mem_addr<=req_addr[winner], rr_ptr<=(winner+1)%NumReq;
//    addr<MemSize -> WAIT, err_q<=0; else -> RESP, err_q<=1 (no memory access).
//    No valid: stay IDLE, rr_ptr unchanged.
//   WAIT: memory samples mem_addr; unconditional -> RESP next edge.
//   RESP: rsp_valid[owner]=1; rsp_data = err_q ? 0 : mem_rdata; rsp_err=err_q.
//    mem_addr held so mem_rdata stays stable. rsp_ready[owner]=1 -> IDLE;
//    else hold (data stable). rsp_ready of non-owners ignored.
//  req_ready=0 outside IDLE; rsp_valid=0 outside RESP.
//  Latency: accept at cycle N -> rsp_valid at N+2 (in range), N+1 (out of range).
//  Peak throughput: one access per 3 cycles (IDLE, WAIT, RESP).
//  Fairness: continuously requesting agents are granted in strict rotation;
//   a single requester is granted back-to-back regardless of rr_ptr.
//  Protocol: requester holds req_valid/req_addr stable until ready; a requester may
//   raise a new request while its response is pending (accepted after return to IDLE).
//  rr_ptr width $clog2(NumReq); wrap computed explicitly, not by overflow.
// STRUCTURE
//  lisp package: typedef word_t logic[lisp::word_size:0]; enum mem_arb_state_t
//   {MA_IDLE, MA_WAIT, MA_RESP}.
//  Sub-module rr_arbiter #(N): combinational; inputs valid[N], ptr; outputs one-hot grant,
//   grant index, any. mem_arbiter holds all state.
// TESTING (memory model preloaded: [0]=16'h0000|TYPE_NUMBER, [1]=16'h2A2A)
//  Single: r0 valid addr 1 -> ready[0] cycle 0, rsp_valid[0] cycle 2, rsp_data=16'h2A2A, err=0.
//  Contention: r0,r1 valid each cycle, rr_ptr=0 -> grant order 0,1,0,1; each rsp to
//   correct owner; no double grant.
//  Backpressure: rsp_ready[1]=0 for 5 cycles -> rsp_valid[1], data held 5 cycles; no new
//   req_ready until accepted; then IDLE.
//  Out of range: addr 1024 -> rsp at cycle 1, rsp_err=1, rsp_data=0.
//  Reset mid-WAIT: rst_n low -> all outputs 0 immediately; after release no stale rsp_valid;
//   next request served from IDLE with rr_ptr=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the lisp word-memory arbiter: word type, FSM states, range check.
package mem_arbiter_pkg;

  localparam int word_size = 15;

  typedef logic [word_size:0] word_t;

  localparam word_t TYPE_NUMBER = 16'h0001;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_WAIT = 2'd1,
    MA_RESP = 2'd2
  } mem_arb_state_t;

  function automatic logic addr_in_range(input word_t addr, input int unsigned mem_size);
    return (32'(addr) < mem_size);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-port bundle between the requesters, the arbiter and the memory.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int NumReq = 2
);

  logic  [NumReq-1:0] req_valid;
  word_t [NumReq-1:0] req_addr;
  logic  [NumReq-1:0] req_ready;
  logic  [NumReq-1:0] rsp_valid;
  logic  [NumReq-1:0] rsp_ready;
  word_t              rsp_data;
  logic               rsp_err;
  word_t              mem_addr;
  word_t              mem_rdata;

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    input  mem_rdata,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err,
    output mem_addr
  );

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    output mem_rdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err,
    input  mem_addr
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr_i, wrapping at N.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [PW:0]   sum_s;
  logic [PW-1:0] cand_s;
  logic [N-1:0]  grant_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // Scan candidates in rotation order; wrap is an explicit subtract, never an overflow.
  always_comb begin
    sum_s   = '0;
    cand_s  = '0;
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_s = {1'b0, ptr_i} + (PW+1)'(i);
      if (sum_s >= (PW+1)'(N)) begin
        sum_s = sum_s - (PW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[PW-1:0];
      if (!found_s && valid_i[cand_s]) begin
        found_s         = 1'b1;
        idx_s           = cand_s;
        grant_s[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_o = grant_s;
  assign idx_o   = idx_s;
  assign any_o   = found_s;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a 1-cycle registered-read word memory between NumReq
// requesters; one access in flight, out-of-range addresses answered with an error.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NumReq  = 2,
  parameter int MemSize = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int PW = (NumReq > 1) ? $clog2(NumReq) : 1;

  mem_arb_state_t state_q;
  logic [PW-1:0]  rr_ptr_q;
  logic [PW-1:0]  rr_ptr_d;
  logic [PW-1:0]  owner_q;
  word_t          mem_addr_q;
  logic           err_q;

  logic [NumReq-1:0] grant_s;
  logic [PW-1:0]     win_idx_s;
  logic              any_s;
  word_t             win_addr_s;
  logic              win_in_range_s;
  logic [NumReq-1:0] owner_onehot_s;

  rr_arbiter #(
    .N  (NumReq),
    .PW (PW)
  ) u_rr (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_s),
    .idx_o   (win_idx_s),
    .any_o   (any_s)
  );

  assign win_addr_s     = bus.req_addr[win_idx_s];
  assign win_in_range_s = addr_in_range(win_addr_s, 32'(MemSize));
  assign owner_onehot_s = NumReq'(1) << owner_q;

  // Pointer moves just past the winner so continuous requesters rotate strictly.
  always_comb begin
    if (win_idx_s == PW'(NumReq - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = win_idx_s + PW'(1);
    end
  end

  // Access sequencer: IDLE grants, WAIT covers the memory read latency, RESP holds data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MA_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      mem_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        MA_IDLE: begin
          if (any_s) begin
            owner_q    <= win_idx_s;
            mem_addr_q <= win_addr_s;
            rr_ptr_q   <= rr_ptr_d;
            if (win_in_range_s) begin
              state_q <= MA_WAIT;
              err_q   <= 1'b0;
            end else begin
              state_q <= MA_RESP;
              err_q   <= 1'b1;
            end
          end else begin
            state_q <= MA_IDLE;
          end
        end
        MA_WAIT: begin
          state_q <= MA_RESP;
        end
        MA_RESP: begin
          if (bus.rsp_ready[owner_q]) begin
            state_q <= MA_IDLE;
          end else begin
            state_q <= MA_RESP;
          end
        end
        default: begin
          state_q <= MA_IDLE;
        end
      endcase
    end
  end

  // Output decode; mem_addr stays put through RESP so mem_rdata remains stable.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    if (rst_n && (state_q == MA_IDLE)) begin
      bus.req_ready = grant_s;
    end else begin
      bus.req_ready = '0;
    end
    if (state_q == MA_RESP) begin
      bus.rsp_valid = owner_onehot_s;
      bus.rsp_err   = err_q;
      bus.rsp_data  = err_q ? '0 : bus.mem_rdata;
    end else begin
      bus.rsp_valid = '0;
    end
  end

  assign bus.mem_addr = mem_addr_q;

endmodule
